// File: rtl/mem_stage.sv
// mem_stage: MIPS MEM stage plus MEM/WB pipeline register.
// Loads and stores go out over a req/ack data-memory port. While an access is in flight,
// MemStall holds the EX/MEM bundle upstream.
// Configuration macro: MEM_SUBWORD_EN enables byte/half accesses with lane steering.
// Without it, every access is a word access.
module mem_stage #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              MemtoReg,
    input  logic              RegWrite,
    input  logic [4:0]        WriteReg,
    input  logic [31:0]       ALUResult,
    input  logic [31:0]       StoreData,
    input  logic [1:0]        MemSize,
    input  logic              MemSigned,
    output logic              DmemReq,
    output logic              DmemWe,
    output logic [ADDR_W-1:0] DmemAddr,
    output logic [31:0]       DmemWData,
    output logic [3:0]        DmemBE,
    input  logic [31:0]       DmemRData,
    input  logic              DmemAck,
    output logic              MemStall,
    output logic              ValidOut,
    output logic              MemtoRegOut,
    output logic              RegWriteOut,
    output logic [4:0]        WriteRegOut,
    output logic [31:0]       ReadData,
    output logic [31:0]       ALUResultOut,
    output logic              AlignErr
);

    typedef enum logic [0:0] {StIdle, StReq} stateE;

    stateE       stateQ, stateD;
    logic        isAccess, aligned, isMemOp, misAlign, isStore;
    logic        stall, latchBundle;
    logic [3:0]  storeBe;
    logic [31:0] storeWData, loadData;

    logic        validD, memtoRegD, regWriteD, alignErrD;
    logic [31:0] readDataD;

    assign isAccess = Valid & (MemRead | MemWrite);
    assign isMemOp  = isAccess & aligned;
    assign misAlign = isAccess & ~aligned;
    // Both MemRead and MemWrite high is treated as a load.
    assign isStore  = MemWrite & ~MemRead;

`ifdef MEM_SUBWORD_EN
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    // Alignment, byte enables and replicated store data by access size
    always_comb begin
        aligned    = (ALUResult[1:0] == 2'b00);
        storeBe    = 4'b1111;
        storeWData = StoreData;
        case (MemSize)
            2'b00: begin
                aligned    = 1'b1;
                storeBe    = 4'b0001 << ALUResult[1:0];
                storeWData = {4{StoreData[7:0]}};
            end
            2'b01: begin
                aligned    = ~ALUResult[0];
                storeBe    = 4'b0011 << ALUResult[1:0];
                storeWData = {2{StoreData[15:0]}};
            end
            default: ;
        endcase
    end

    // Load lane select and zero/sign extension
    always_comb begin
        loadByte = DmemRData[8*ALUResult[1:0] +: 8];
        loadHalf = DmemRData[16*ALUResult[1] +: 16];
        loadData = DmemRData;
        case (MemSize)
            2'b00:   loadData = {{24{MemSigned & loadByte[7]}}, loadByte};
            2'b01:   loadData = {{16{MemSigned & loadHalf[15]}}, loadHalf};
            default: loadData = DmemRData;
        endcase
    end
`else
    logic unusedSubword;

    // Word-only build: size controls are ignored
    assign unusedSubword = ^{MemSize, MemSigned};
    assign aligned       = (ALUResult[1:0] == 2'b00);
    assign storeBe       = 4'b1111;
    assign storeWData    = StoreData;
    assign loadData      = DmemRData;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // FSM next state and stall; IDLE spends one stall cycle before raising the request
    always_comb begin
        stateD = stateQ;
        stall  = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (isMemOp) begin
                    stall  = 1'b1;
                    stateD = StReq;
                end
            end
            StReq: begin
                if (DmemAck) begin
                    stateD = StIdle;
                end else begin
                    stall = 1'b1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // Memory port is quiet outside REQ; stall drops at once when reset asserts
    always_comb begin
        DmemReq   = (stateQ == StReq);
        DmemWe    = DmemReq & isStore;
        DmemAddr  = DmemReq ? {ALUResult[ADDR_W-1:2], 2'b00} : '0;
        DmemWData = DmemReq ? storeWData : '0;
        DmemBE    = DmemReq ? storeBe : 4'b0000;
        MemStall  = rst_n & stall;
    end

    // MEM/WB next values: the bundle retires or a bubble is inserted while waiting
    always_comb begin
        latchBundle = ((stateQ == StIdle) & ~isMemOp) | ((stateQ == StReq) & DmemAck);
        validD      = 1'b0;
        memtoRegD   = 1'b0;
        regWriteD   = 1'b0;
        alignErrD   = 1'b0;
        readDataD   = '0;
        if (latchBundle) begin
            validD    = Valid;
            memtoRegD = MemtoReg;
            regWriteD = RegWrite & ~misAlign;
            alignErrD = (stateQ == StIdle) & misAlign;
            if ((stateQ == StReq) && !isStore) begin
                readDataD = loadData;
            end
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ValidOut     <= 1'b0;
            MemtoRegOut  <= 1'b0;
            RegWriteOut  <= 1'b0;
            WriteRegOut  <= '0;
            ReadData     <= '0;
            ALUResultOut <= '0;
            AlignErr     <= 1'b0;
        end else begin
            ValidOut     <= validD;
            MemtoRegOut  <= memtoRegD;
            RegWriteOut  <= regWriteD;
            WriteRegOut  <= WriteReg;
            ReadData     <= readDataD;
            ALUResultOut <= ALUResult;
            AlignErr     <= alignErrD;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; expectations are hand-computed constants.
module tb_mem_stage;

    logic        clk, rst_n;
    logic        Valid, MemRead, MemWrite, MemtoReg, RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] ALUResult, StoreData;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic        DmemReq, DmemWe;
    logic [31:0] DmemAddr, DmemWData;
    logic [3:0]  DmemBE;
    logic [31:0] DmemRData;
    logic        DmemAck, MemStall;
    logic        ValidOut, MemtoRegOut, RegWriteOut, AlignErr;
    logic [4:0]  WriteRegOut;
    logic [31:0] ReadData, ALUResultOut;

    int total;
    int bad;
    int stalls;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .Valid(Valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .WriteReg(WriteReg), .ALUResult(ALUResult),
        .StoreData(StoreData), .MemSize(MemSize), .MemSigned(MemSigned), .DmemReq(DmemReq),
        .DmemWe(DmemWe), .DmemAddr(DmemAddr), .DmemWData(DmemWData), .DmemBE(DmemBE),
        .DmemRData(DmemRData), .DmemAck(DmemAck), .MemStall(MemStall), .ValidOut(ValidOut),
        .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut), .WriteRegOut(WriteRegOut),
        .ReadData(ReadData), .ALUResultOut(ALUResultOut), .AlignErr(AlignErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        Valid = 0; MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0;
        WriteReg = 0; ALUResult = 0; StoreData = 0; MemSize = 2'b10; MemSigned = 0;
    endtask

    task automatic setLoad(input logic [31:0] addr, input logic [1:0] size, input logic sgn);
        Valid = 1; MemRead = 1; MemWrite = 0; MemtoReg = 1; RegWrite = 1;
        WriteReg = 5'd9; ALUResult = addr; MemSize = size; MemSigned = sgn;
    endtask

    // Load with a same-cycle ack in the first REQ cycle
    task automatic doLoad(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                          input logic [31:0] rdata);
        setLoad(addr, size, sgn);
        tick();
        DmemAck = 1; DmemRData = rdata;
        tick();
        DmemAck = 0;
        clearIn();
    endtask

`ifdef MEM_SUBWORD_EN
    localparam logic [31:0] StAddr = 32'h102;
    localparam logic [1:0]  StSize = 2'b01;
    localparam logic [31:0] StAddrW = 32'h100;
    localparam logic [3:0]  StBe = 4'b1100;
    localparam logic [31:0] StWd = 32'hABCDABCD;
`else
    localparam logic [31:0] StAddr = 32'h104;
    localparam logic [1:0]  StSize = 2'b10;
    localparam logic [31:0] StAddrW = 32'h104;
    localparam logic [3:0]  StBe = 4'b1111;
    localparam logic [31:0] StWd = 32'h0000ABCD;
`endif

    initial begin
        total = 0; bad = 0; stalls = 0;
        rst_n = 0; DmemAck = 0; DmemRData = 0;
        clearIn();

        // Reset state
        #12;
        check("rst_valid", ValidOut, 0);
        check("rst_regwrite", RegWriteOut, 0);
        check("rst_readdata", ReadData, 0);
        check("rst_alu", ALUResultOut, 0);
        check("rst_alignerr", AlignErr, 0);
        check("rst_req", DmemReq, 0);
        rst_n = 1;

        // ALU op passes through in one cycle, no stall
        Valid = 1; RegWrite = 1; ALUResult = 32'h1234; WriteReg = 5'd5;
        #1;
        check("alu_stall", MemStall, 0);
        tick();
        check("alu_result", ALUResultOut, 32'h1234);
        check("alu_valid", ValidOut, 1);
        check("alu_wreg", WriteRegOut, 5);
        check("alu_regwrite", RegWriteOut, 1);
        check("alu_memtoreg", MemtoRegOut, 0);
        clearIn();

        // lw 0x100, ack in third REQ cycle
        setLoad(32'h100, 2'b10, 0);
        #1;
        check("lw_idle_req", DmemReq, 0);
        stalls = stalls + int'(MemStall);
        tick();
        check("lw_req", DmemReq, 1);
        check("lw_addr", DmemAddr, 32'h100);
        check("lw_we", DmemWe, 0);
        check("lw_be", DmemBE, 4'hF);
        check("lw_bubble", ValidOut, 0);
        stalls = stalls + int'(MemStall);
        tick();
        stalls = stalls + int'(MemStall);
        tick();
        DmemAck = 1; DmemRData = 32'hDEADBEEF;
        #1;
        check("lw_ack_stall", MemStall, 0);
        stalls = stalls + int'(MemStall);
        tick();
        DmemAck = 0;
        clearIn();
        check("lw_stall_cycles", stalls, 3);
        check("lw_data", ReadData, 32'hDEADBEEF);
        check("lw_memtoreg", MemtoRegOut, 1);
        check("lw_valid", ValidOut, 1);
        check("lw_wreg", WriteRegOut, 9);
        check("lw_done_req", DmemReq, 0);

        // Store
        Valid = 1; MemWrite = 1; ALUResult = StAddr; MemSize = StSize;
        StoreData = 32'h0000ABCD;
        #1;
        check("st_idle_stall", MemStall, 1);
        tick();
        check("st_req", DmemReq, 1);
        check("st_we", DmemWe, 1);
        check("st_addr", DmemAddr, StAddrW);
        check("st_be", DmemBE, StBe);
        check("st_wdata", DmemWData, StWd);
        DmemAck = 1;
        tick();
        DmemAck = 0;
        clearIn();
        check("st_valid", ValidOut, 1);
        check("st_readdata", ReadData, 0);
        check("st_regwrite", RegWriteOut, 0);

`ifdef MEM_SUBWORD_EN
        doLoad(32'h103, 2'b00, 1, 32'h80FF_0000);
        check("lb_signed", ReadData, 32'hFFFFFF80);
        doLoad(32'h103, 2'b00, 0, 32'h80FF_0000);
        check("lbu", ReadData, 32'h00000080);
        doLoad(32'h102, 2'b01, 1, 32'h80FF_0000);
        check("lh_signed", ReadData, 32'hFFFF80FF);
`else
        doLoad(32'h108, 2'b00, 1, 32'h8135_7924);
        check("lw_size_ignored", ReadData, 32'h81357924);
`endif

        // Misaligned lw retires immediately with AlignErr
        setLoad(32'h101, 2'b10, 0);
        #1;
        check("mis_req", DmemReq, 0);
        check("mis_stall", MemStall, 0);
        tick();
        check("mis_alignerr", AlignErr, 1);
        check("mis_regwrite", RegWriteOut, 0);
        check("mis_valid", ValidOut, 1);
        clearIn();
        tick();
        check("mis_clear", AlignErr, 0);

        // Ack outside REQ ignored
        DmemAck = 1;
        #1;
        check("idle_ack_req", DmemReq, 0);
        tick();
        check("idle_ack_valid", ValidOut, 0);
        check("idle_ack_req2", DmemReq, 0);
        DmemAck = 0;

        // Reset during REQ
        setLoad(32'h200, 2'b10, 0);
        tick();
        check("rr_req", DmemReq, 1);
        #2;
        rst_n = 0;
        #1;
        check("rr_req_drop", DmemReq, 0);
        check("rr_stall_drop", MemStall, 0);
        check("rr_valid", ValidOut, 0);
        check("rr_readdata", ReadData, 0);
        #2;
        rst_n = 1;
        #1;
        check("rr_restart_stall", MemStall, 1);
        check("rr_restart_idle", DmemReq, 0);
        tick();
        check("rr_restart_req", DmemReq, 1);
        check("rr_restart_addr", DmemAddr, 32'h200);
        DmemAck = 1; DmemRData = 32'hCAFEF00D;
        tick();
        DmemAck = 0;
        clearIn();
        check("rr_data", ReadData, 32'hCAFEF00D);
        check("rr_valid2", ValidOut, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
